serial_pattern_detector: RTL and testbench
==========================================

// Module: serial_pattern_detector
// PURPOSE
//   Parametrised successor of the fixed-sequence serial-line FSM. Detects a
//   runtime-programmable, maskable PATTERN_W-bit sequence on a 1-bit serial
//   line qualified by a valid strobe. Supports overlapping and non-overlapping
//   detection. Sits between the serial front end and event/interrupt logic.
// PARAMETERS
//   PATTERN_W  4  pattern length in bits (2..32)
//   COUNT_W    8  match counter width (used only with SERIAL_PATTERN_DET_COUNT_EN)
// PORTS
//   clock        in   1          single clock, all logic on posedge
//   reset        in   1          synchronous, active-low; 0 = reset
//   enable       in   1          1 = detect; 0 = idle, flush history
//   serial_valid in   1          qualifies serial_line this cycle
//   serial_line  in   1          serial data bit
//   pattern      in   PATTERN_W  target; MSB = first bit received
//   mask         in   PATTERN_W  1 = compare bit, 0 = don't care
//   overlap      in   1          1 = overlapping, 0 = non-overlapping
//   match        out  1          one-cycle pulse per detection
//   busy         out  1          1 when state != IDLE
//   match_count  out  COUNT_W    saturating match count (macro only)
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, history=0, fill=0, match=0,
//     busy=0, match_count=0. Reset has priority over every other input.
//   FSM states: IDLE, FILL, DETECT.
//     IDLE  : enable==1 -> FILL; latches pattern, mask, overlap into cfg regs.
//     FILL  : each valid bit: history={history[W-2:0],serial_line}, fill++.
//             fill reaches PATTERN_W on this bit -> DETECT (compare this bit).
//     DETECT: each valid bit shifts history; compare runs every valid bit.
//     Any state, enable==0 -> IDLE next cycle; history/fill cleared; no match.
//   Compare: hit = ((next_history ^ cfg_pattern) & cfg_mask) == 0, evaluated
//     only on a valid bit with the PATTERN_W-th (or later) bit.
//   match: registered; high exactly the cycle after the posedge that sampled
//     the completing bit (latency 1). Otherwise 0. Never high two cycles for
//     one bit.
//   overlap==1: after hit stay DETECT, history kept (1011011 hits twice).
//   overlap==0: after hit fill=0, history=0, -> FILL; next hit needs
//     PATTERN_W fresh valid bits.
//   serial_valid==0: no shift, no compare, no state change; match=0.
//   Config changes on pattern/mask/overlap while enabled are ignored until
//     the next IDLE->FILL transition.
//   mask==0: every valid bit from the PATTERN_W-th onward is a hit.
//   fill width = $clog2(PATTERN_W+1); fill saturates at PATTERN_W.
// CONFIGURATION
//   SERIAL_PATTERN_DET_COUNT_EN defined: match_count port present; increments
//     by 1 on each match pulse (same cycle match is driven high); saturates at
//     2**COUNT_W-1; cleared by reset or enable==0.
//   Not defined: match_count port and counter absent; all else identical.
// STRUCTURE
//   Package serial_fsm_pkg: typedef enum {IDLE,FILL,DETECT} det_state_t; state
//     encoding constants; PATTERN_W_MAX=32.
//   Sub-module serial_history_reg: PATTERN_W-bit valid-qualified shift
//     register with synchronous clear (reset, flush). FSM, compare, counter
//     stay in this module.
// TESTING (PATTERN_W=4, pattern=4'b1011, mask=4'b1111, valid=1 unless stated)
//   1 Reset: drive 1011, then reset=0 for 1 cycle -> match=0, busy=0, count=0,
//     next 3 bits 011 give no hit.
//   2 overlap=1, stream 1011011 -> match high after bits 4 and 7 (2 pulses).
//   3 overlap=0, stream 1011011 -> one pulse after bit 4; stream 10111011 ->
//     pulses after bits 4 and 8.
//   4 mask=4'b1001, pattern=4'b1001: streams 1001 and 1111 each -> 1 pulse;
//     1110 -> none.
//   5 valid gaps: 1,x(valid=0),0,1,x(valid=0),1 -> single pulse 1 cycle after
//     final valid bit; invalid cycles never pulse.
//   6 COUNT_EN, COUNT_W=2, overlap=1, stream 1011011011011011 -> 5 pulses,
//     match_count=3 (saturated); enable=0 -> count=0, busy=0.

Source files
------------

// File: rtl/serial_fsm_pkg.sv
// ---------------------------------------------------------------------------
// Package: serial_fsm_pkg
// Purpose: shared state type and constants for serial_pattern_detector and
//          its history shift register.
// Contents:
//   PATTERN_W_MAX     largest supported pattern length
//   ST_*              explicit state encodings
//   det_state_t       detector FSM state type (IDLE, FILL, DETECT)
// ---------------------------------------------------------------------------
package serial_fsm_pkg;

    localparam int PATTERN_W_MAX = 32;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_FILL   = 2'b01;
    localparam logic [1:0] ST_DETECT = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FILL   = ST_FILL,
        DETECT = ST_DETECT
    } det_state_t;

endpackage : serial_fsm_pkg

// File: rtl/serial_history_reg.sv
// ---------------------------------------------------------------------------
// Module: serial_history_reg
// Purpose: PATTERN_W-bit shift register holding the most recent valid serial
//          bits (newest bit in bit 0). Shifts only when shift_en is high;
//          clear empties the window and takes priority over a shift.
// Ports:
//   clock     in   1          posedge clock
//   reset     in   1          synchronous, active-low
//   clear     in   1          synchronous clear (flush / non-overlap restart)
//   shift_en  in   1          shift bit_in into the window this cycle
//   bit_in    in   1          serial data bit
//   history   out  PATTERN_W  registered window
// ---------------------------------------------------------------------------
import serial_fsm_pkg::*;

module serial_history_reg #(
    parameter int PATTERN_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [PATTERN_W-1:0] history
);

    logic [PATTERN_W-1:0] hist_d;
    logic [PATTERN_W-1:0] hist_q;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (shift_en) begin
            hist_d = (hist_q << 1) | PATTERN_W'(bit_in);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign history = hist_q;

endmodule : serial_history_reg

// File: rtl/serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// Module: serial_pattern_detector
// Purpose: detects a programmable, maskable PATTERN_W-bit sequence on a
//          valid-qualified serial line, with overlapping or non-overlapping
//          detection. pattern/mask/overlap are captured on IDLE->FILL and
//          held for the whole enabled session.
// Optional feature: define SERIAL_PATTERN_DET_COUNT_EN to add the saturating
//          match_count output.
// Ports:
//   clock         in   1          posedge clock
//   reset         in   1          synchronous, active-low
//   enable        in   1          1 = detect, 0 = idle and flush history
//   serial_valid  in   1          qualifies serial_line
//   serial_line   in   1          serial data bit
//   pattern       in   PATTERN_W  target, MSB = first bit received
//   mask          in   PATTERN_W  1 = compare bit, 0 = don't care
//   overlap       in   1          1 = overlapping detection
//   match         out  1          one-cycle pulse per detection (registered)
//   busy          out  1          state != IDLE
//   match_count   out  COUNT_W    saturating match count (macro only)
// ---------------------------------------------------------------------------
import serial_fsm_pkg::*;

module serial_pattern_detector #(
    parameter int PATTERN_W = 4,
    parameter int COUNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 serial_valid,
    input  logic                 serial_line,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [PATTERN_W-1:0] mask,
    input  logic                 overlap,
    output logic                 match,
    output logic                 busy
`ifdef SERIAL_PATTERN_DET_COUNT_EN
    ,
    output logic [COUNT_W-1:0]   match_count
`endif
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);

    if (PATTERN_W < 2 || PATTERN_W > PATTERN_W_MAX || COUNT_W < 1) begin : g_bad_params
        $error("serial_pattern_detector: PATTERN_W must be 2..32 and COUNT_W >= 1");
    end

    det_state_t           state_d, state_q;
    logic [FILL_W-1:0]    fill_d, fill_q;
    logic [PATTERN_W-1:0] cfg_pattern_d, cfg_pattern_q;
    logic [PATTERN_W-1:0] cfg_mask_d, cfg_mask_q;
    logic                 cfg_overlap_d, cfg_overlap_q;
    logic                 match_d, match_q;

    logic [PATTERN_W-1:0] history;
    logic [PATTERN_W-1:0] next_history;
    logic                 hist_clear;
    logic                 hist_shift;
    logic                 hit;

    serial_history_reg #(
        .PATTERN_W (PATTERN_W)
    ) u_history (
        .clock    (clock),
        .reset    (reset),
        .clear    (hist_clear),
        .shift_en (hist_shift),
        .bit_in   (serial_line),
        .history  (history)
    );

    // Compare against the window as it will look after this bit, so a hit
    // is registered on the same edge that samples the completing bit.
    assign next_history = (history << 1) | PATTERN_W'(serial_line);

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        cfg_pattern_d = cfg_pattern_q;
        cfg_mask_d    = cfg_mask_q;
        cfg_overlap_d = cfg_overlap_q;
        hist_clear    = 1'b0;
        hist_shift    = 1'b0;
        hit           = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            fill_d     = '0;
            hist_clear = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d       = FILL;
                    fill_d        = '0;
                    cfg_pattern_d = pattern;
                    cfg_mask_d    = mask;
                    cfg_overlap_d = overlap;
                end
                FILL: begin
                    if (serial_valid) begin
                        hist_shift = 1'b1;
                        if (fill_q == FILL_LAST) begin
                            // This bit completes the window: compare now.
                            fill_d  = FILL_FULL;
                            state_d = DETECT;
                            hit     = ((next_history ^ cfg_pattern_q) & cfg_mask_q) == '0;
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                end
                DETECT: begin
                    if (serial_valid) begin
                        hist_shift = 1'b1;
                        hit        = ((next_history ^ cfg_pattern_q) & cfg_mask_q) == '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Non-overlapping: a hit consumes the window, so the next hit
            // needs PATTERN_W fresh bits. Clear beats the shift above.
            if (hit && !cfg_overlap_q) begin
                hist_clear = 1'b1;
                fill_d     = '0;
                state_d    = FILL;
            end
        end

        match_d = hit;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            fill_q        <= '0;
            cfg_pattern_q <= '0;
            cfg_mask_q    <= '0;
            cfg_overlap_q <= 1'b0;
            match_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            cfg_pattern_q <= cfg_pattern_d;
            cfg_mask_q    <= cfg_mask_d;
            cfg_overlap_q <= cfg_overlap_d;
            match_q       <= match_d;
        end
    end

    assign match = match_q;
    assign busy  = (state_q != IDLE);

`ifdef SERIAL_PATTERN_DET_COUNT_EN
    logic [COUNT_W-1:0] count_d, count_q;

    // Counts in step with match_q so the count and the pulse appear together.
    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (hit && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// ---------------------------------------------------------------------------
// Testbench: tb_serial_pattern_detector
// Directed tests for serial_pattern_detector with PATTERN_W=4, COUNT_W=2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Count checks are compiled in only when
// SERIAL_PATTERN_DET_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_pattern_detector;

    localparam int W  = 4;
    localparam int CW = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         serial_valid;
    logic         serial_line;
    logic [W-1:0] pattern;
    logic [W-1:0] mask;
    logic         overlap;
    logic         match;
    logic         busy;
`ifdef SERIAL_PATTERN_DET_COUNT_EN
    logic [CW-1:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_pattern_detector #(
        .PATTERN_W (W),
        .COUNT_W   (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .serial_valid (serial_valid),
        .serial_line  (serial_line),
        .pattern      (pattern),
        .mask         (mask),
        .overlap      (overlap),
        .match        (match),
        .busy         (busy)
`ifdef SERIAL_PATTERN_DET_COUNT_EN
        ,
        .match_count  (match_count)
`endif
    );

    // Drive n bits MSB-first; got[n-1-i] is match sampled after bit i's edge.
    task automatic drive_stream(input logic [31:0] bits, input logic [31:0] valids,
                                input int n, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            serial_line  = bits[n-1-i];
            serial_valid = valids[n-1-i];
            @(posedge clock);
            #1;
            got[n-1-i] = match;
        end
        @(negedge clock);
        serial_valid = 1'b0;
        serial_line  = 1'b0;
    endtask

    // One disabled cycle, then enable with a new config; returns on the
    // negedge where enable rises, so the next edge performs IDLE->FILL.
    task automatic restart(input logic [W-1:0] pat, input logic [W-1:0] msk, input logic ovl);
        @(negedge clock);
        enable       = 1'b0;
        serial_valid = 1'b0;
        @(negedge clock);
        pattern = pat;
        mask    = msk;
        overlap = ovl;
        enable  = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        // Power-on reset state.
        @(posedge clock);
        #1;
        checks++;
        if (match !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL por_state: match=%b busy=%b expected 0 0", match, busy);
        end
        @(negedge clock);
        reset = 1'b1;

        restart(4'b1011, 4'b1111, 1'b1);
        drive_stream(32'b101, 32'b111, 3, got);
        checks++;
        if (got !== 32'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: got=%b busy=%b expected 000 1", got[2:0], busy);
        end

        // Completing bit arrives together with reset: reset must win.
        serial_line  = 1'b1;
        serial_valid = 1'b1;
        reset        = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (match !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: match=%b busy=%b expected 0 0", match, busy);
        end
`ifdef SERIAL_PATTERN_DET_COUNT_EN
        checks++;
        if (match_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", match_count);
        end
`endif
        @(negedge clock);
        reset        = 1'b1;
        serial_valid = 1'b0;
        drive_stream(32'b011, 32'b111, 3, got);
        checks++;
        if (got !== 32'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_history_cleared: got=%b busy=%b expected 000 1", got[2:0], busy);
        end
    endtask

    task automatic test_overlap();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b1);
        drive_stream(32'b1011011, 32'b1111111, 7, got);
        checks++;
        if (got !== 32'b0001001) begin
            errors++;
            $display("FAIL overlap_1011011: got %b expected 0001001", got[6:0]);
        end
    endtask

    task automatic test_non_overlap();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b0);
        drive_stream(32'b1011011, 32'b1111111, 7, got);
        checks++;
        if (got !== 32'b0001000) begin
            errors++;
            $display("FAIL nonoverlap_1011011: got %b expected 0001000", got[6:0]);
        end
        restart(4'b1011, 4'b1111, 1'b0);
        drive_stream(32'b10111011, 32'b11111111, 8, got);
        checks++;
        if (got !== 32'b00010001) begin
            errors++;
            $display("FAIL nonoverlap_10111011: got %b expected 00010001", got[7:0]);
        end
    endtask

    task automatic test_mask();
        logic [31:0] got;
        restart(4'b1001, 4'b1001, 1'b0);
        drive_stream(32'b1001, 32'b1111, 4, got);
        checks++;
        if (got !== 32'b0001) begin
            errors++;
            $display("FAIL mask_1001: got %b expected 0001", got[3:0]);
        end
        restart(4'b1001, 4'b1001, 1'b0);
        drive_stream(32'b1111, 32'b1111, 4, got);
        checks++;
        if (got !== 32'b0001) begin
            errors++;
            $display("FAIL mask_1111: got %b expected 0001", got[3:0]);
        end
        restart(4'b1001, 4'b1001, 1'b0);
        drive_stream(32'b1110, 32'b1111, 4, got);
        checks++;
        if (got !== 32'b0000) begin
            errors++;
            $display("FAIL mask_1110: got %b expected 0000", got[3:0]);
        end
        // Empty mask: every bit from the 4th onward is a hit.
        restart(4'b1011, 4'b0000, 1'b1);
        drive_stream(32'b010010, 32'b111111, 6, got);
        checks++;
        if (got !== 32'b000111) begin
            errors++;
            $display("FAIL mask_zero: got %b expected 000111", got[5:0]);
        end
    endtask

    task automatic test_valid_gaps();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b1);
        // 1, gap, 0, 1, gap, 1 ; gap cycles carry line=0.
        drive_stream(32'b100101, 32'b101101, 6, got);
        checks++;
        if (got !== 32'b000001) begin
            errors++;
            $display("FAIL valid_gaps: got %b expected 000001", got[5:0]);
        end
        @(posedge clock);
        #1;
        checks++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle_pulse: match=%b expected 0", match);
        end
    endtask

    task automatic test_config_hold();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b1);
        drive_stream(32'b10, 32'b11, 2, got);
        // Changed while enabled: must have no effect on this session.
        pattern = 4'b0000;
        mask    = 4'b1111;
        overlap = 1'b0;
        drive_stream(32'b11011, 32'b11111, 5, got);
        checks++;
        if (got !== 32'b01001) begin
            errors++;
            $display("FAIL config_hold: got %b expected 01001", got[4:0]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b1);
        drive_stream(32'b101, 32'b111, 3, got);
        enable = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy=%b match=%b expected 0 0", busy, match);
        end
        @(negedge clock);
        enable = 1'b1;
        // Stale 101 would make the first bit a hit; flushed history must not.
        drive_stream(32'b1011, 32'b1111, 4, got);
        checks++;
        if (got !== 32'b0001) begin
            errors++;
            $display("FAIL flush_history: got %b expected 0001", got[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        restart(4'b1011, 4'b1111, 1'b1);
        drive_stream(32'b1011011011011011, 32'hFFFF, 16, got);
        checks++;
        if (got !== 32'b0001001001001001) begin
            errors++;
            $display("FAIL back_to_back: got %b expected 0001001001001001", got[15:0]);
        end
`ifdef SERIAL_PATTERN_DET_COUNT_EN
        checks++;
        if (match_count !== 2'd3) begin
            errors++;
            $display("FAIL count_saturate: got %0d expected 3", match_count);
        end
`endif
        enable = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL disable_idle: busy=%b match=%b expected 0 0", busy, match);
        end
`ifdef SERIAL_PATTERN_DET_COUNT_EN
        checks++;
        if (match_count !== 2'd0) begin
            errors++;
            $display("FAIL count_clear: got %0d expected 0", match_count);
        end
`endif
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        serial_valid = 1'b0;
        serial_line  = 1'b0;
        pattern      = '0;
        mask         = '0;
        overlap      = 1'b0;

        test_reset();
        test_overlap();
        test_non_overlap();
        test_mask();
        test_valid_gaps();
        test_config_hold();
        test_flush();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_pattern_detector
